// File: rtl/deploy_request_ctrl_pkg.sv
// Shared constants, types and helpers for the HUD deploy-request controller.
// Slot numbering: 0 purse, 1-8 army types, 9 tower fire.
package deploy_pkg;

  localparam logic [3:0] SLOT_PURSE = 4'd0;
  localparam logic [3:0] SLOT_FIRE  = 4'd9;
  localparam int         COST_W     = 15;

  // Army unit prices, index 0 is slot 1.
  localparam logic [COST_W-1:0] ARMY_COST [8] = '{
    15'd75, 15'd150, 15'd240, 15'd350, 15'd750, 15'd1500, 15'd2000, 15'd2400
  };

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } deploy_state_t;

  // Purse and fire are priced by the engine, so they report zero here.
  function automatic logic [COST_W-1:0] army_cost(input logic [3:0] slot);
    if (slot >= 4'd1 && slot <= 4'd8) return ARMY_COST[3'(slot - 4'd1)];
    return '0;
  endfunction

  // Heavy units (slots 5-8) get the long cooldown.
  function automatic int unsigned cd_reload(input logic [3:0] slot,
                                            input int unsigned cd_short,
                                            input int unsigned cd_long);
    return (slot >= 4'd5) ? cd_long : cd_short;
  endfunction

endpackage

// File: rtl/deploy_request_ctrl_if.sv
// Request channel from the click controller to Game_Engine.
// Handshake: req_valid stays high with req_slot/req_cost stable until the cycle
// in which the engine raises req_ack; the transfer completes on that edge.
interface deploy_request_ctrl_if;
  import deploy_pkg::*;

  logic              req_valid;
  logic [3:0]        req_slot;
  logic [COST_W-1:0] req_cost;
  logic              req_ack;

  modport master (output req_valid, output req_slot, output req_cost, input req_ack);
  modport slave  (input req_valid, input req_slot, input req_cost, output req_ack);

endinterface

// File: rtl/deploy_request_ctrl_cd_timer.sv
// Per-slot cooldown down-counter in frames; load beats tick, clear beats both.
// busy is registered from the next count so it lines up with the counter.
module cd_timer #(
  parameter int CD_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic [CD_W-1:0] load_val,
  input  logic            tick,
  output logic            busy,
  output logic [CD_W-1:0] count
);

  logic [CD_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_val;
    end else if (tick && count != '0) begin
      count_next = count - CD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      count <= count_next;
      busy  <= (count_next != '0);
    end
  end

endmodule

// File: rtl/deploy_request_ctrl.sv
// Converts HUD clicks into single deploy/purchase requests for Game_Engine,
// gating them on affordability and per-unit cooldowns.
module deploy_request_ctrl
  import deploy_pkg::*;
#(
  parameter int unsigned CD_W     = 8,
  parameter int unsigned CD_SHORT = 60,
  parameter int unsigned CD_LONG  = 180
) (
  input  logic                  clk_25MHz,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  play_active,
  input  logic                  mouse_l,
  input  logic [9:0]            mouse_in_frame,
  input  logic [COST_W-1:0]     money,
  input  logic                  purse_upgradable,
  input  logic                  tower_ready,
  deploy_request_ctrl_if.master req,
  output logic [9:0]            cd_busy,
  output deploy_state_t         fsm_state
);

  deploy_state_t   state, state_next;
  logic            mouse_l_q;
  logic            click;
  logic            hit;
  logic [3:0]      hit_slot;
  logic            eligible;
  logic            launch;
  logic            accept;
  logic [8:1]      busy_vec;
  logic [15:0]     cd_idle;
  logic [CD_W-1:0] cd_count [1:8];

  always_ff @(posedge clk_25MHz) begin
    if (rst) mouse_l_q <= 1'b0;
    else     mouse_l_q <= mouse_l;
  end

  assign click = mouse_l & ~mouse_l_q;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_slot = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (mouse_in_frame[i]) begin
        hit      = 1'b1;
        hit_slot = 4'(i);
      end
    end
  end

  always_comb begin
    cd_idle = '1;
    for (int s = 1; s <= 8; s++) cd_idle[s] = (cd_count[s] == '0);
  end

  always_comb begin
    case (hit_slot)
      SLOT_PURSE: eligible = purse_upgradable;
      SLOT_FIRE:  eligible = tower_ready;
      default:    eligible = (money >= army_cost(hit_slot)) && cd_idle[hit_slot];
    endcase
  end

  assign launch = (state == IDLE) && play_active && click && hit && eligible;
  // An ack coinciding with play_active dropping is discarded with the request.
  assign accept = (state == PENDING) && play_active && req.req_ack;

  always_ff @(posedge clk_25MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!play_active) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (launch) state_next = PENDING;
        PENDING: if (req.req_ack) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    req.req_valid = (state == PENDING);
    fsm_state     = state;
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      req.req_slot <= 4'd0;
      req.req_cost <= '0;
    end else if (launch) begin
      req.req_slot <= hit_slot;
      req.req_cost <= army_cost(hit_slot);
    end
  end

  for (genvar g = 1; g <= 8; g++) begin : g_cd
    cd_timer #(.CD_W(CD_W)) u_cd (
      .clk      (clk_25MHz),
      .rst      (rst),
      .clear    (~play_active),
      .load     (accept && (req.req_slot == 4'(g))),
      .load_val (CD_W'(cd_reload(4'(g), CD_SHORT, CD_LONG))),
      .tick     (frame_tick),
      .busy     (busy_vec[g]),
      .count    (cd_count[g])
    );
  end

  assign cd_busy = {1'b0, busy_vec, 1'b0};

endmodule

// File: tb/tb_deploy_request_ctrl.sv
// Bench for deploy_request_ctrl: directed scenarios plus random traffic,
// all compared against a frame/click-level reference model.
module tb_deploy_request_ctrl;
  import deploy_pkg::*;

  logic          clk_25MHz = 1'b0;
  logic          rst;
  logic          frame_tick;
  logic          play_active;
  logic          mouse_l;
  logic [9:0]    mouse_in_frame;
  logic [14:0]   money;
  logic          purse_upgradable;
  logic          tower_ready;
  logic [9:0]    cd_busy;
  deploy_state_t fsm_state;

  deploy_request_ctrl_if bus ();

  int checks = 0;
  int errors = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  deploy_request_ctrl #(.CD_W(8), .CD_SHORT(60), .CD_LONG(180)) dut (
    .clk_25MHz        (clk_25MHz),
    .rst              (rst),
    .frame_tick       (frame_tick),
    .play_active      (play_active),
    .mouse_l          (mouse_l),
    .mouse_in_frame   (mouse_in_frame),
    .money            (money),
    .purse_upgradable (purse_upgradable),
    .tower_ready      (tower_ready),
    .req              (bus.master),
    .cd_busy          (cd_busy),
    .fsm_state        (fsm_state)
  );

  // Reference model: game rules expressed with plain integers.
  int costs [10] = '{0, 75, 150, 240, 350, 750, 1500, 2000, 2400, 0};
  bit m_prev;
  bit m_pend;
  int m_slot;
  int m_cost;
  int m_cd [10];

  always @(posedge clk_25MHz) begin : ref_model
    bit clk_click;
    int hit;
    int loaded;
    bit ok;
    if (rst) begin
      m_prev = 0; m_pend = 0; m_slot = 0; m_cost = 0;
      for (int s = 0; s < 10; s++) m_cd[s] = 0;
    end else begin
      clk_click = mouse_l && !m_prev;
      m_prev = mouse_l;
      loaded = -1;
      if (!play_active) begin
        m_pend = 0;
        for (int s = 0; s < 10; s++) m_cd[s] = 0;
      end else begin
        if (m_pend) begin
          if (bus.req_ack) begin
            m_pend = 0;
            if (m_slot >= 1 && m_slot <= 8) loaded = m_slot;
          end
        end else begin
          hit = -1;
          for (int i = 0; i < 10; i++) if (mouse_in_frame[i] && hit < 0) hit = i;
          ok = (hit == 0 && purse_upgradable) || (hit == 9 && tower_ready) ||
               (hit >= 1 && hit <= 8 && int'(money) >= costs[hit] && m_cd[hit] == 0);
          if (clk_click && hit >= 0 && ok) begin
            m_pend = 1; m_slot = hit; m_cost = costs[hit];
          end
        end
        for (int s = 1; s <= 8; s++) begin
          if (s == loaded) m_cd[s] = (s <= 4) ? 60 : 180;
          else if (frame_tick && m_cd[s] > 0) m_cd[s] = m_cd[s] - 1;
        end
      end
    end
  end

  function automatic logic [29:0] exp_vec();
    logic [9:0] b;
    for (int s = 0; s < 10; s++) b[s] = (m_cd[s] != 0);
    return {m_pend, 4'(m_slot), 15'(m_cost), b};
  endfunction

  task automatic step();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; frame_tick = 1; play_active = 1; mouse_l = 1;
    mouse_in_frame = 10'b00_0000_0010; money = 15'd100;
    purse_upgradable = 1; tower_ready = 1; bus.req_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== 30'd0 || fsm_state !== IDLE) begin
        errors++;
        $display("FAIL reset_state act=%h exp=0", {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy});
      end
      checks++;
    end
    frame_tick = 0; bus.req_ack = 0; purse_upgradable = 0; tower_ready = 0;
  endtask

  task automatic test_click_once();
    int rises = 0;
    logic prev_valid = 1'b0;
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec() || fsm_state !== (m_pend ? PENDING : IDLE)) begin
        errors++;
        $display("FAIL click_hold act=%h exp=%h", {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy}, exp_vec());
      end
      checks++;
      if (i == 0) begin
        if (bus.req_valid !== 1'b1 || bus.req_slot !== 4'd1 || bus.req_cost !== 15'd75) begin
          errors++;
          $display("FAIL click_latency valid=%b slot=%0d cost=%0d exp 1/1/75", bus.req_valid, bus.req_slot, bus.req_cost);
        end
        checks++;
      end
      if (bus.req_valid && !prev_valid) rises++;
      prev_valid = bus.req_valid;
    end
    if (rises != 1) begin
      errors++;
      $display("FAIL click_single rises=%0d exp=1", rises);
    end
    checks++;
    mouse_l = 0; bus.req_ack = 1;
    step();
    bus.req_ack = 0;
    if (bus.req_valid !== 1'b0 || cd_busy !== 10'b00_0000_0010) begin
      errors++;
      $display("FAIL ack_load valid=%b cd_busy=%b exp 0/0000000010", bus.req_valid, cd_busy);
    end
    checks++;
  endtask

  task automatic test_cooldown();
    for (int t = 1; t <= 59; t++) begin
      frame_tick = 1;
      step();
      frame_tick = 0;
      step();
      if ({bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec() || fsm_state !== (m_pend ? PENDING : IDLE)) begin
        errors++;
        $display("FAIL cooldown_run t=%0d act=%h exp=%h", t, {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy}, exp_vec());
      end
      checks++;
    end
    mouse_l = 1;
    step();
    mouse_l = 0;
    if (bus.req_valid !== 1'b0 || cd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL cooldown_block valid=%b busy1=%b exp 0/1", bus.req_valid, cd_busy[1]);
    end
    checks++;
    step();
    frame_tick = 1;
    step();
    frame_tick = 0;
    if (cd_busy[1] !== 1'b0 || {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec()) begin
      errors++;
      $display("FAIL cooldown_expire busy1=%b exp=0", cd_busy[1]);
    end
    checks++;
  endtask

  task automatic test_afford();
    mouse_in_frame = 10'b01_0000_0000;
    money = 15'd2399; mouse_l = 1;
    step();
    mouse_l = 0;
    if (bus.req_valid !== 1'b0 || {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec()) begin
      errors++;
      $display("FAIL afford_short valid=%b exp=0", bus.req_valid);
    end
    checks++;
    step();
    money = 15'd2400; mouse_l = 1;
    step();
    mouse_l = 0;
    if (bus.req_valid !== 1'b1 || bus.req_slot !== 4'd8 || bus.req_cost !== 15'd2400) begin
      errors++;
      $display("FAIL afford_exact valid=%b slot=%0d cost=%0d exp 1/8/2400", bus.req_valid, bus.req_slot, bus.req_cost);
    end
    checks++;
    bus.req_ack = 1;
    step();
    bus.req_ack = 0;
    if ({bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec() || cd_busy[8] !== 1'b1) begin
      errors++;
      $display("FAIL afford_ack act=%h exp=%h", {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy}, exp_vec());
    end
    checks++;
  endtask

  task automatic test_priority();
    mouse_in_frame = 10'b10_0000_0001; purse_upgradable = 1; mouse_l = 1;
    step();
    mouse_l = 0;
    if (bus.req_valid !== 1'b1 || bus.req_slot !== 4'd0 || bus.req_cost !== 15'd0) begin
      errors++;
      $display("FAIL prio_purse valid=%b slot=%0d cost=%0d exp 1/0/0", bus.req_valid, bus.req_slot, bus.req_cost);
    end
    checks++;
    bus.req_ack = 1;
    step();
    bus.req_ack = 0;
    mouse_in_frame = 10'b10_0000_0000; tower_ready = 0; mouse_l = 1;
    step();
    mouse_l = 0;
    if (bus.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fire_not_ready valid=%b exp=0", bus.req_valid);
    end
    checks++;
    step();
    tower_ready = 1; mouse_l = 1;
    step();
    mouse_l = 0;
    if (bus.req_valid !== 1'b1 || bus.req_slot !== 4'd9 || {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec()) begin
      errors++;
      $display("FAIL fire_ready valid=%b slot=%0d exp 1/9", bus.req_valid, bus.req_slot);
    end
    checks++;
    bus.req_ack = 1;
    step();
    bus.req_ack = 0;
  endtask

  task automatic test_hold();
    money = 15'd5000; mouse_in_frame = 10'b00_0000_1000; mouse_l = 1;
    step();
    mouse_l = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin mouse_in_frame = 10'b00_0000_0100; mouse_l = 1; end
      if (i == 3) mouse_l = 0;
      step();
      if (bus.req_valid !== 1'b1 || bus.req_slot !== 4'd3 || {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec()) begin
        errors++;
        $display("FAIL hold_stable i=%0d valid=%b slot=%0d exp 1/3", i, bus.req_valid, bus.req_slot);
      end
      checks++;
    end
    bus.req_ack = 1;
    step();
    bus.req_ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.req_valid !== 1'b0 || {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec()) begin
        errors++;
        $display("FAIL hold_no_queue i=%0d valid=%b exp=0", i, bus.req_valid);
      end
      checks++;
    end
  endtask

  task automatic test_abort();
    mouse_in_frame = 10'b00_0001_0000; mouse_l = 1;
    step();
    mouse_l = 0; play_active = 0; bus.req_ack = 1;
    step();
    bus.req_ack = 0;
    if (bus.req_valid !== 1'b0 || cd_busy !== 10'd0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL abort_drop valid=%b cd_busy=%b exp 0/0", bus.req_valid, cd_busy);
    end
    checks++;
    play_active = 1;
    step();
    if (cd_busy !== 10'd0 || {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec()) begin
      errors++;
      $display("FAIL abort_no_load cd_busy=%b exp=0", cd_busy);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      play_active      = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 2) == 0) mouse_l = ~mouse_l;
      case ($urandom_range(0, 3))
        0: mouse_in_frame = 10'd0;
        1: mouse_in_frame = 10'(10'd1 << $urandom_range(0, 9));
        default: mouse_in_frame = 10'($urandom_range(0, 1023));
      endcase
      money            = 15'($urandom_range(0, 3000));
      purse_upgradable = 1'($urandom_range(0, 1));
      tower_ready      = 1'($urandom_range(0, 1));
      frame_tick       = ($urandom_range(0, 2) == 0);
      bus.req_ack      = ($urandom_range(0, 3) == 0);
      step();
      if ({bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== exp_vec() || fsm_state !== (m_pend ? PENDING : IDLE)) begin
        errors++;
        $display("FAIL random i=%0d act=%h exp=%h", i, {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy}, exp_vec());
      end
      checks++;
    end
    frame_tick = 0; bus.req_ack = 0;
  endtask

  task automatic test_reset_mid();
    play_active = 0; mouse_l = 0; money = 15'd3000;
    step();
    play_active = 1;
    step();
    mouse_in_frame = 10'b00_0010_0000; mouse_l = 1;
    step();
    mouse_l = 0; bus.req_ack = 1;
    step();
    bus.req_ack = 0;
    mouse_in_frame = 10'b00_0100_0000; mouse_l = 1;
    step();
    if (bus.req_valid !== 1'b1 || bus.req_slot !== 4'd6 || cd_busy[5] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup valid=%b slot=%0d busy5=%b exp 1/6/1", bus.req_valid, bus.req_slot, cd_busy[5]);
    end
    checks++;
    mouse_l = 0; rst = 1;
    step();
    rst = 0;
    if ({bus.req_valid, bus.req_slot, bus.req_cost, cd_busy} !== 30'd0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL midrst_clear act=%h exp=0", {bus.req_valid, bus.req_slot, bus.req_cost, cd_busy});
    end
    checks++;
  endtask

  initial begin
    bus.req_ack = 0;
    test_reset();
    test_click_once();
    test_cooldown();
    test_afford();
    test_priority();
    test_hold();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
